affine_mcm_pipe: RTL and testbench

Pipelined, parametrised multiple-constant multiplier for the interpolation datapath. It multiplies each signed input sample by a four-coefficient set using shift-add logic only (no hardware multipliers). The coefficient bank is selectable per sample: bank 0 = {1,2,3,4}, bank 1 = {5,6,7,8}. It sits between the sample fetch stage and the filter adder tree, and adds a valid/ready stream with full backpressure.

---
 rtl/affine_pkg.sv | 28 ++
 rtl/affine_mcm_core.sv | 53 +++++
 rtl/affine_mcm_pipe.sv | 116 +++++++++++
 tb/tb_affine_mcm_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/affine_pkg.sv
// ============================================================================
// affine_pkg : bank encodings and coefficient tables for affine_mcm_pipe
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package affine_pkg;

  localparam logic BANK_A1  = 1'b0;
  localparam logic BANK_A2  = 1'b1;
  localparam int   NUM_COEF = 4;

  // Index 0 holds c1 of the bank.
  localparam logic [NUM_COEF-1:0][3:0] COEF_A1 = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [NUM_COEF-1:0][3:0] COEF_A2 = {4'd8, 4'd7, 4'd6, 4'd5};

  function automatic int unsigned coef(input logic bank, input int unsigned idx);
    logic [1:0] sel;
    sel = idx[1:0];
    if (bank == BANK_A2) begin
      return {28'd0, COEF_A2[sel]};
    end
    return {28'd0, COEF_A1[sel]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/affine_mcm_core.sv
// ============================================================================
// affine_mcm_core : combinational shift-add multiply by the selected bank
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module affine_mcm_core
  import affine_pkg::*;
#(
  parameter int OW = 16
) (
  input  logic signed [OW-1:0] x,
  input  logic                 bank,
  output logic signed [OW-1:0] y1,
  output logic signed [OW-1:0] y2,
  output logic signed [OW-1:0] y3,
  output logic signed [OW-1:0] y4
);

  logic signed [OW-1:0] w_w1;
  logic signed [OW-1:0] w_w2;
  logic signed [OW-1:0] w_w4;
  logic signed [OW-1:0] w_w8;

  assign w_w1 = x;
  assign w_w2 = x <<< 1;
  assign w_w4 = x <<< 2;
  assign w_w8 = x <<< 3;

  always_comb begin
    y1 = w_w1;
    y2 = w_w2;
    y3 = w_w4 - w_w1;
    y4 = w_w4;
    case (bank)
      BANK_A2: begin
        y1 = w_w4 + w_w1;
        y2 = w_w4 + w_w2;
        y3 = w_w8 - w_w1;
        y4 = w_w8;
      end
      default: begin
        y1 = w_w1;
        y2 = w_w2;
        y3 = w_w4 - w_w1;
        y4 = w_w4;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/affine_mcm_pipe.sv
// ============================================================================
// affine_mcm_pipe : two-stage valid/ready multiple-constant multiplier
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module affine_mcm_pipe
  import affine_pkg::*;
#(
  parameter int IW = 8,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_x,
  input  logic                 in_bank,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_y1,
  output logic signed [OW-1:0] out_y2,
  output logic signed [OW-1:0] out_y3,
  output logic signed [OW-1:0] out_y4,
  output logic                 out_bank,
  output logic                 out_last
);

  if (OW < IW + 4) begin : g_ow_check
    $error("affine_mcm_pipe: OW must be at least IW+4");
  end

  logic                 r_s1_valid;
  logic                 r_s1_bank;
  logic                 r_s1_last;
  logic signed [OW-1:0] r_s1_x;

  logic                 r_s2_valid;
  logic                 r_s2_bank;
  logic                 r_s2_last;
  logic signed [OW-1:0] r_s2_y1;
  logic signed [OW-1:0] r_s2_y2;
  logic signed [OW-1:0] r_s2_y3;
  logic signed [OW-1:0] r_s2_y4;

  logic                 w_s1_adv;
  logic                 w_s2_adv;
  logic signed [OW-1:0] w_y1;
  logic signed [OW-1:0] w_y2;
  logic signed [OW-1:0] w_y3;
  logic signed [OW-1:0] w_y4;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  affine_mcm_core #(
    .OW (OW)
  ) u_core (
    .x    (r_s1_x),
    .bank (r_s1_bank),
    .y1   (w_y1),
    .y2   (w_y2),
    .y3   (w_y3),
    .y4   (w_y4)
  );

  // Data registers load only with a valid sample so an idle pipe keeps its last outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_bank  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_x     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_bank  <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_y1    <= '0;
      r_s2_y2    <= '0;
      r_s2_y3    <= '0;
      r_s2_y4    <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_x    <= {{(OW-IW){in_x[IW-1]}}, in_x};
          r_s1_bank <= in_bank;
          r_s1_last <= in_last;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_y1   <= w_y1;
          r_s2_y2   <= w_y2;
          r_s2_y3   <= w_y3;
          r_s2_y4   <= w_y4;
          r_s2_bank <= r_s1_bank;
          r_s2_last <= r_s1_last;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_y1    = r_s2_y1;
  assign out_y2    = r_s2_y2;
  assign out_y3    = r_s2_y3;
  assign out_y4    = r_s2_y4;
  assign out_bank  = r_s2_bank;
  assign out_last  = r_s2_last;

endmodule

`default_nettype wire

// File: tb/tb_affine_mcm_pipe.sv
// ============================================================================
// tb_affine_mcm_pipe : directed vector table plus stream/backpressure/reset sequences
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_affine_mcm_pipe;
  import affine_pkg::*;

  localparam int IW = 8;
  localparam int OW = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_x;
  logic                 in_bank;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_y1;
  logic signed [OW-1:0] out_y2;
  logic signed [OW-1:0] out_y3;
  logic signed [OW-1:0] out_y4;
  logic                 out_bank;
  logic                 out_last;

  affine_mcm_pipe #(
    .IW (IW),
    .OW (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_bank   (in_bank),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y1    (out_y1),
    .out_y2    (out_y2),
    .out_y3    (out_y3),
    .out_y4    (out_y4),
    .out_bank  (out_bank),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int out_beats = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic signed [IW-1:0] x;
    logic                 bank;
    logic                 last;
  } sb_t;
  sb_t sb[$];

  logic                 hold_prev = 1'b0;
  logic signed [OW-1:0] p_y1, p_y2, p_y3, p_y4;
  logic                 p_bank, p_last;

  // Scoreboard and output-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          sb_t s;
          s = sb.pop_front();
          check("sb_y1",   out_y1, int'(s.x) * int'(coef(s.bank, 0)));
          check("sb_y2",   out_y2, int'(s.x) * int'(coef(s.bank, 1)));
          check("sb_y3",   out_y3, int'(s.x) * int'(coef(s.bank, 2)));
          check("sb_y4",   out_y4, int'(s.x) * int'(coef(s.bank, 3)));
          check("sb_bank", out_bank, s.bank);
          check("sb_last", out_last, s.last);
        end
        out_beats++;
      end
      if (in_valid && in_ready) begin
        sb_t n;
        n.x = in_x; n.bank = in_bank; n.last = in_last;
        sb.push_back(n);
      end
      if (hold_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_y1", out_y1, p_y1);
        check("stall_y2", out_y2, p_y2);
        check("stall_y3", out_y3, p_y3);
        check("stall_y4", out_y4, p_y4);
        check("stall_bank", out_bank, p_bank);
        check("stall_last", out_last, p_last);
      end
      hold_prev = out_valid && !out_ready;
      p_y1 = out_y1; p_y2 = out_y2; p_y3 = out_y3; p_y4 = out_y4;
      p_bank = out_bank; p_last = out_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic run_cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int x;
    bit bank;
    bit last;
    int y1, y2, y3, y4;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    int base;
    int sent;
    int cyc;
    int bx[4];
    bit bb[4];

    vecs[0] = '{3,    1'b0, 1'b0,    3,    6,    9,    12};
    vecs[1] = '{-128, 1'b1, 1'b0, -640, -768, -896, -1024};
    vecs[2] = '{127,  1'b1, 1'b1,  635,  762,  889,  1016};
    vecs[3] = '{-1,   1'b0, 1'b1,   -1,   -2,   -3,    -4};
    vecs[4] = '{0,    1'b1, 1'b0,    0,    0,    0,     0};
    vecs[5] = '{-5,   1'b1, 1'b1,  -25,  -30,  -35,   -40};
    vecs[6] = '{100,  1'b0, 1'b0,  100,  200,  300,   400};
    vecs[7] = '{-128, 1'b0, 1'b1, -128, -256, -384,  -512};

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_bank = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y1", out_y1, 0);
    check("rst_y4", out_y4, 0);
    check("rst_bank", out_bank, 0);
    check("rst_last", out_last, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single-beat directed vectors: one output beat two edges after acceptance.
    for (int i = 0; i < 8; i++) begin
      in_x = vecs[i].x[IW-1:0]; in_bank = vecs[i].bank; in_last = vecs[i].last;
      in_valid = 1'b1;
      run_cycle(acc);
      check("tbl_accept", acc, 1);
      in_valid = 1'b0;
      check("tbl_lat1_valid", out_valid, 0);
      run_cycle(acc);
      check("tbl_valid", out_valid, 1);
      check("tbl_y1", out_y1, vecs[i].y1);
      check("tbl_y2", out_y2, vecs[i].y2);
      check("tbl_y3", out_y3, vecs[i].y3);
      check("tbl_y4", out_y4, vecs[i].y4);
      check("tbl_bank", out_bank, vecs[i].bank);
      check("tbl_last", out_last, vecs[i].last);
      run_cycle(acc);
      check("tbl_one_beat", out_valid, 0);
      check("tbl_hold_y4", out_y4, vecs[i].y4);
    end

    // Stream 1..20 with alternating bank, full throughput.
    base = out_beats;
    for (int i = 0; i < 20; i++) begin
      in_x = IW'(i + 1); in_bank = i[0]; in_last = (i % 5 == 4);
      in_valid = 1'b1;
      run_cycle(acc);
      check("stream_accept", acc, 1);
      if (i >= 1) check("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    run_cycle(acc);
    check("stream_tail_valid", out_valid, 1);
    run_cycle(acc);
    check("stream_end_valid", out_valid, 0);
    check("stream_beats", out_beats - base, 20);

    // Backpressure: two samples absorbed, then in_ready drops.
    bx = '{11, -22, 33, -44};
    bb = '{1'b1, 1'b0, 1'b1, 1'b0};
    base = out_beats;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_x = IW'(bx[idx]); in_bank = bb[idx]; in_last = 1'b0;
      run_cycle(acc);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_y1", out_y1, 55);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    cyc = 0;
    while ((idx < 4 || out_valid) && cyc < 20) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_x = IW'(bx[idx]); in_bank = bb[idx];
      end
      run_cycle(acc);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_drain_timeout", cyc < 20, 1);
    check("bp_all_accepted", idx, 4);
    check("bp_beats", out_beats - base, 4);

    // Random valid/ready traffic.
    base = out_beats;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = $urandom_range(0, 1);
      in_x      = IW'($urandom);
      in_bank   = $urandom_range(0, 1);
      in_last   = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      run_cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    check("rnd_sent", sent, 1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || out_valid) && cyc < 10) begin
      run_cycle(acc);
      cyc++;
    end
    check("rnd_sb_empty", sb.size(), 0);
    check("rnd_beats", out_beats - base, 1000);

    // Reset with two samples in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 8'sd50; in_bank = 1'b0; in_last = 1'b1;
    run_cycle(acc);
    in_x = -8'sd7; in_bank = 1'b1; in_last = 1'b0;
    run_cycle(acc);
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_y4", out_y4, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y1", out_y1, 0);
    check("mid_rst_y2", out_y2, 0);
    check("mid_rst_y3", out_y3, 0);
    check("mid_rst_y4", out_y4, 0);
    check("mid_rst_last", out_last, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = out_beats;
    in_valid = 1'b1; in_x = 8'sd9; in_bank = 1'b1; in_last = 1'b1;
    run_cycle(acc);
    in_valid = 1'b0;
    check("post_rst_lat1", out_valid, 0);
    run_cycle(acc);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_y1", out_y1, 45);
    check("post_rst_y2", out_y2, 54);
    check("post_rst_y3", out_y3, 63);
    check("post_rst_y4", out_y4, 72);
    check("post_rst_bank", out_bank, 1);
    run_cycle(acc);
    check("post_rst_alone", out_valid, 0);
    run_cycle(acc);
    check("post_rst_beats", out_beats - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
